// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory burst arbiter.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_A = 2'd1,
        BURST_B = 2'd2
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    localparam int unsigned LEN_W_DEF   = 4;
    localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/dm_burst_gen.sv
// Burst address generator: captures base/length at grant, steps one word per beat.
module dm_burst_gen
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [31:0]      base_in,
    input  logic [LEN_W-1:0] len_in,
    output logic [31:0]      addr,
    output logic             last
);

    logic [31:0]      base_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else if (load) begin
            base_q <= base_in & ~32'h3;
            cnt_q  <= '0;
            last_q <= len_in;
        end else if (advance) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // 32-bit add wraps naturally past the top of the address space.
    assign addr = base_q + (32'(cnt_q) * WORD_STRIDE);
    assign last = (cnt_q == last_q);

endmodule

// File: rtl/dm_arbiter.sv
// Two-master round-robin burst arbiter driving a single-port data memory.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [31:0]      a_addr,
    input  logic [LEN_W-1:0] a_len,
    input  logic [31:0]      a_wdata,
    output logic             a_gnt,
    output logic             a_ack,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [31:0]      b_addr,
    input  logic [LEN_W-1:0] b_len,
    input  logic [31:0]      b_wdata,
    output logic             b_gnt,
    output logic             b_ack,
    output logic [31:0]      rdata,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_din,
    output logic             mem_we,
    input  logic [31:0]      mem_dout
);

    state_t           state;
    owner_t           prio;
    logic             we_q;
    logic             a_elig, b_elig;
    logic             arb_point, grant_a, grant_b;
    logic             burst_last;
    logic [31:0]      burst_addr;
    logic [31:0]      sel_addr;
    logic [LEN_W-1:0] sel_len;

    assign a_gnt = (state == BURST_A);
    assign b_gnt = (state == BURST_B);
    assign a_ack = a_gnt;
    assign b_ack = b_gnt;

    // A master's own req is masked while it holds the grant, so a held req
    // only re-arbitrates after the handoff.
    always_comb begin
        a_elig    = a_req && !a_gnt;
        b_elig    = b_req && !b_gnt;
        arb_point = (state == IDLE) || burst_last;
        grant_a   = arb_point && a_elig && (!b_elig || prio == OWN_A);
        grant_b   = arb_point && b_elig && (!a_elig || prio == OWN_B);
        sel_addr  = grant_b ? b_addr : a_addr;
        sel_len   = grant_b ? b_len  : a_len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            prio  <= OWN_A;
            we_q  <= 1'b0;
        end else if (grant_a) begin
            state <= BURST_A;
            prio  <= OWN_B;
            we_q  <= a_we;
        end else if (grant_b) begin
            state <= BURST_B;
            prio  <= OWN_A;
            we_q  <= b_we;
        end else if (arb_point) begin
            state <= IDLE;
            we_q  <= 1'b0;
        end
    end

    dm_burst_gen #(.LEN_W(LEN_W)) u_burst_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (grant_a || grant_b),
        .advance (state != IDLE),
        .base_in (sel_addr),
        .len_in  (sel_len),
        .addr    (burst_addr),
        .last    (burst_last)
    );

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        unique case (state)
            BURST_A: begin
                mem_addr = burst_addr;
                mem_din  = a_wdata;
                mem_we   = we_q;
            end
            BURST_B: begin
                mem_addr = burst_addr;
                mem_din  = b_wdata;
                mem_we   = we_q;
            end
            default: ;
        endcase
    end

    assign rdata = mem_dout;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural 1K-word memory.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_len, b_len;
    logic        a_gnt, a_ack, b_gnt, b_ack, mem_we;
    logic [31:0] rdata, mem_addr, mem_din, mem_dout;

    logic [31:0] mem [0:1023] = '{default: '0};

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_din;
    assign mem_dout = mem[mem_addr[11:2]];

    dm_arbiter #(.LEN_W(4)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_len(a_len), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_ack(b_ack),
        .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_len = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_len = '0; b_wdata = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({a_gnt, a_ack, b_gnt, b_ack, mem_we} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl: got %b want 00000", {a_gnt, a_ack, b_gnt, b_ack, mem_we});
        end
        total++;
        if (mem_addr !== 32'h0 || mem_din !== 32'h0) begin
            bad++; $display("FAIL reset_bus: got addr %h din %h want 0 0", mem_addr, mem_din);
        end
        next_cycle();
    endtask

    task automatic test_write_burst();
        do_reset();
        a_req = 1; a_we = 1; a_addr = 32'h100; a_len = 4'd3;
        next_cycle();
        a_req = 0; a_addr = 32'hFFF0; a_len = 4'd0; a_we = 0;
        for (int i = 0; i < 4; i++) begin
            a_wdata = 32'hA0 + 32'(i);
            @(negedge clk);
            total++;
            if ({a_gnt, a_ack, b_gnt, mem_we} !== 4'b1101) begin
                bad++; $display("FAIL wr_ctl beat %0d: got %b want 1101", i, {a_gnt, a_ack, b_gnt, mem_we});
            end
            total++;
            if (mem_addr !== 32'h100 + 32'(4 * i) || mem_din !== 32'hA0 + 32'(i)) begin
                bad++; $display("FAIL wr_bus beat %0d: got %h/%h want %h/%h", i, mem_addr, mem_din,
                                32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (a_gnt !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL wr_end: got gnt %b we %b want 0 0", a_gnt, mem_we);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[10'h40 + 10'(i)] !== 32'hA0 + 32'(i)) begin
                bad++; $display("FAIL wr_mem %0d: got %h want %h", i, mem[10'h40 + 10'(i)], 32'hA0 + 32'(i));
            end
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        a_req = 1; a_we = 1; a_addr = 32'h0; a_len = 4'd0; a_wdata = 32'h11;
        b_req = 1; b_we = 0; b_addr = 32'h0; b_len = 4'd1;
        next_cycle();
        a_req = 0;
        @(negedge clk);
        total++;
        if ({a_gnt, b_gnt, mem_we} !== 3'b101 || mem_addr !== 32'h0 || mem_din !== 32'h11) begin
            bad++; $display("FAIL b2b_a: got %b %h %h want 101 0 11", {a_gnt, b_gnt, mem_we}, mem_addr, mem_din);
        end
        next_cycle();
        b_req = 0;
        @(negedge clk);
        total++;
        if ({a_gnt, b_gnt, b_ack, mem_we} !== 4'b0110 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL b2b_b0: got %b %h want 0110 0", {a_gnt, b_gnt, b_ack, mem_we}, mem_addr);
        end
        total++;
        if (rdata !== 32'h11) begin
            bad++; $display("FAIL b2b_rdata: got %h want 00000011", rdata);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if ({a_gnt, b_gnt} !== 2'b01 || mem_addr !== 32'h4) begin
            bad++; $display("FAIL b2b_b1: got %b %h want 01 4", {a_gnt, b_gnt}, mem_addr);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if ({a_gnt, b_gnt} !== 2'b00) begin
            bad++; $display("FAIL b2b_end: got %b want 00", {a_gnt, b_gnt});
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [7:0]  exp_a;
        logic [31:0] exp_addr [8];
        exp_a = 8'b00110011;  // bit i = cycle i
        exp_addr = '{32'h300, 32'h304, 32'h400, 32'h404, 32'h300, 32'h304, 32'h400, 32'h404};
        do_reset();
        a_req = 1; a_addr = 32'h300; a_len = 4'd1;
        b_req = 1; b_addr = 32'h400; b_len = 4'd1;
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (a_gnt !== exp_a[i] || b_gnt !== !exp_a[i] || mem_addr !== exp_addr[i]) begin
                bad++; $display("FAIL rr cycle %0d: got a%b b%b %h want a%b b%b %h", i, a_gnt, b_gnt,
                                mem_addr, exp_a[i], !exp_a[i], exp_addr[i]);
            end
            next_cycle();
        end
        a_req = 0; b_req = 0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_wrap();
        do_reset();
        b_req = 1; b_we = 0; b_addr = 32'hFFFF_FFF8; b_len = 4'd3;
        next_cycle();
        b_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || mem_addr !== 32'hFFFF_FFF8 + 32'(4 * i)) begin
                bad++; $display("FAIL wrap beat %0d: got b%b a%b %h want b1 a0 %h", i, b_gnt, a_gnt,
                                mem_addr, 32'hFFFF_FFF8 + 32'(4 * i));
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        a_req = 1; a_we = 1; a_addr = 32'h500; a_len = 4'd7;
        next_cycle();
        a_req = 0;
        for (int i = 0; i < 2; i++) begin
            a_wdata = 32'hC0 + 32'(i);
            @(negedge clk);
            total++;
            if (a_gnt !== 1'b1 || mem_addr !== 32'h500 + 32'(4 * i)) begin
                bad++; $display("FAIL rmid beat %0d: got %b %h want 1 %h", i, a_gnt, mem_addr, 32'h500 + 32'(4 * i));
            end
            if (i == 1) reset = 1'b1;
            next_cycle();
        end
        a_wdata = 32'hC2;
        @(negedge clk);
        total++;
        if ({a_gnt, a_ack, b_gnt, b_ack, mem_we} !== 5'b0 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL rmid_idle: got %b %h want 00000 0", {a_gnt, a_ack, b_gnt, b_ack, mem_we}, mem_addr);
        end
        total++;
        if (mem[10'h140] !== 32'hC0 || mem[10'h141] !== 32'hC1 || mem[10'h142] !== 32'h0) begin
            bad++; $display("FAIL rmid_mem: got %h %h %h want c0 c1 0", mem[10'h140], mem[10'h141], mem[10'h142]);
        end
        reset = 1'b0;
        a_req = 1; a_we = 0; a_len = 4'd0;
        b_req = 1; b_we = 0; b_len = 4'd0;
        next_cycle();
        a_req = 0;
        @(negedge clk);
        total++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            bad++; $display("FAIL rmid_prio: got %b want 10", {a_gnt, b_gnt});
        end
        b_req = 0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_unaligned();
        do_reset();
        a_req = 1; a_we = 0; a_addr = 32'h203; a_len = 4'd1;
        next_cycle();
        a_req = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (a_gnt !== 1'b1 || mem_addr !== 32'h200 + 32'(4 * i)) begin
                bad++; $display("FAIL unaligned beat %0d: got %b %h want 1 %h", i, a_gnt, mem_addr, 32'h200 + 32'(4 * i));
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (a_gnt !== 1'b0) begin
            bad++; $display("FAIL unaligned_end: got %b want 0", a_gnt);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_back_to_back();
        test_round_robin();
        test_wrap();
        test_reset_mid_burst();
        test_unaligned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
